wb_port_arbiter: RTL and testbench

- Sequences the single register-file write port and the writeback-select mux between two sources.
- Source 1: the in-order pipeline writeback (PC+4 or ALU result). Source 2: a multi-cycle load unit returning data asynchronously to the pipeline.
- Holds one returning load in a skid buffer, grants the port each cycle, and stalls the pipeline on conflict.
- Includes a starvation guard so loads cannot block the pipeline forever.

---
 rtl/wb_port_if.sv | 36 +++
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 tb/tb_wb_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_if.sv
// Writeback port bundle: pipeline writeback, load-unit return and the
// register-file write side, grouped so the arbiter and its driver share one view.
interface wb_port_if #(
  parameter int unsigned XLEN = 32
);
  logic            pipe_valid;
  logic            pipe_is_jal;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pc_four;
  logic [XLEN-1:0] alu_data;
  logic            pipe_stall;

  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;

  logic [1:0]      wb_sel;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rd_addr;
  logic            rd_wren;

  modport master (
    output pipe_valid, pipe_is_jal, pipe_rd, pc_four, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  pipe_stall, ld_ready,
    input  wb_sel, wb_data, rd_addr, rd_wren
  );

  modport slave (
    input  pipe_valid, pipe_is_jal, pipe_rd, pc_four, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output pipe_stall, ld_ready,
    output wb_sel, wb_data, rd_addr, rd_wren
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// and a one-entry load skid buffer, with a starvation guard for the pipeline.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_port_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_LD  = 2'd2;

  logic            buf_valid_q, buf_valid_d;
  logic [4:0]      buf_rd_q,    buf_rd_d;
  logic [XLEN-1:0] buf_data_q,  buf_data_d;
  logic [3:0]      starve_q,    starve_d;

  logic [1:0]      wb_sel_q,    wb_sel_d;
  logic [XLEN-1:0] wb_data_q,   wb_data_d;
  logic [4:0]      rd_addr_q,   rd_addr_d;
  logic            rd_wren_q,   rd_wren_d;

  logic grant_ld;
  logic grant_pipe;
  logic capture;

  // The buffered load wins unless the pipeline has already waited out its limit.
  always_comb begin
    grant_ld   = buf_valid_q && !(bus.pipe_valid && (starve_q == LIMIT));
    grant_pipe = bus.pipe_valid && !grant_ld;
    capture    = bus.ld_valid && (!buf_valid_q || grant_ld);
  end

  assign bus.pipe_stall = bus.pipe_valid && !grant_pipe;
  assign bus.ld_ready   = !buf_valid_q || grant_ld;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    wb_sel_d    = wb_sel_q;
    wb_data_d   = wb_data_q;
    rd_addr_d   = rd_addr_q;
    rd_wren_d   = 1'b0;

    if (grant_ld) begin
      wb_sel_d    = SEL_LD;
      wb_data_d   = buf_data_q;
      rd_addr_d   = buf_rd_q;
      rd_wren_d   = (buf_rd_q != 5'd0);
      buf_valid_d = 1'b0;
    end else if (grant_pipe) begin
      wb_sel_d    = bus.pipe_is_jal ? SEL_PC : SEL_ALU;
      wb_data_d   = bus.pipe_is_jal ? bus.pc_four : bus.alu_data;
      rd_addr_d   = bus.pipe_rd;
      rd_wren_d   = (bus.pipe_rd != 5'd0);
    end

    // Capture after the drain so a same-edge refill keeps the new entry.
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = bus.ld_rd;
      buf_data_d  = bus.ld_data;
    end

    // A contended load grant is only possible below the limit, so no overflow.
    starve_d = (grant_ld && bus.pipe_valid) ? (starve_q + 4'd1) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      starve_q    <= '0;
      wb_sel_q    <= SEL_PC;
      wb_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_wren_q   <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      starve_q    <= starve_d;
      wb_sel_q    <= wb_sel_d;
      wb_data_q   <= wb_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_wren_q   <= rd_wren_d;
    end
  end

  assign bus.wb_sel  = wb_sel_q;
  assign bus.wb_data = wb_data_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_wren = rd_wren_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, mid-run
// reset, then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_if #(.XLEN(XLEN)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pv;
    logic        jal;
    logic [4:0]  prd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldd;
    logic        es;
    logic        er;
    logic        ew;
    logic [1:0]  esel;
    logic [31:0] edata;
    logic [4:0]  eaddr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(logic pv, logic jal, logic [4:0] prd, logic [31:0] pc,
                               logic [31:0] alu, logic lv, logic [4:0] lrd, logic [31:0] ldd,
                               logic es, logic er, logic ew, logic [1:0] esel,
                               logic [31:0] edata, logic [4:0] eaddr);
    vec_t v;
    v.pv = pv; v.jal = jal; v.prd = prd; v.pc = pc; v.alu = alu;
    v.lv = lv; v.lrd = lrd; v.ldd = ldd;
    v.es = es; v.er = er; v.ew = ew; v.esel = esel; v.edata = edata; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic jal, input logic [4:0] prd,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldd);
    bus.pipe_valid  = pv;
    bus.pipe_is_jal = jal;
    bus.pipe_rd     = prd;
    bus.pc_four     = pc;
    bus.alu_data    = alu;
    bus.ld_valid    = lv;
    bus.ld_rd       = lrd;
    bus.ld_data     = ldd;
  endtask

  task automatic chk_regs(input string tag, input logic ew, input logic [1:0] esel,
                          input logic [31:0] edata, input logic [4:0] eaddr);
    chk({tag, ".rd_wren"}, 64'(bus.rd_wren), 64'(ew));
    chk({tag, ".wb_sel"},  64'(bus.wb_sel),  64'(esel));
    chk({tag, ".wb_data"}, 64'(bus.wb_data), 64'(edata));
    chk({tag, ".rd_addr"}, 64'(bus.rd_addr), 64'(eaddr));
  endtask

  // Reference model state for the random phase
  logic [36:0] mq[$];
  int          wait_cnt;
  logic        e_wren;
  logic [1:0]  e_sel;
  logic [31:0] e_data;
  logic [4:0]  e_addr;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_regs("reset0", 0, 0, 0, 0);
    chk("reset0.ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("reset0.pipe_stall", 64'(bus.pipe_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pipeline only
    tv.push_back(mkv(1,1,5,32'd7,0,            0,0,0,            0,1, 1,0,32'd7,5));
    tv.push_back(mkv(1,0,5,0,32'hfffffabd,     0,0,0,            0,1, 1,1,32'hfffffabd,5));
    // load only
    tv.push_back(mkv(0,0,0,0,0,                1,9,32'hfffaabcd, 0,1, 0,1,32'hfffffabd,5));
    tv.push_back(mkv(0,0,0,0,0,                0,0,0,            0,1, 1,2,32'hfffaabcd,9));
    tv.push_back(mkv(0,0,0,0,0,                0,0,0,            0,1, 0,2,32'hfffaabcd,9));
    // contention with continuous loads: pipeline wins the 4th contended cycle
    tv.push_back(mkv(0,0,0,0,0,                1,3,32'ha0,       0,1, 0,2,32'hfffaabcd,9));
    tv.push_back(mkv(1,0,7,0,32'h55,           1,4,32'ha1,       1,1, 1,2,32'ha0,3));
    tv.push_back(mkv(1,0,7,0,32'h55,           1,5,32'ha2,       1,1, 1,2,32'ha1,4));
    tv.push_back(mkv(1,0,7,0,32'h55,           1,6,32'ha3,       1,1, 1,2,32'ha2,5));
    tv.push_back(mkv(1,0,7,0,32'h55,           1,8,32'ha4,       0,0, 1,1,32'h55,7));
    tv.push_back(mkv(0,0,0,0,0,                1,8,32'ha4,       0,1, 1,2,32'ha3,6));
    // rd=0 pipeline write: stalls once behind the buffer, then updates with wren=0
    tv.push_back(mkv(1,1,0,32'h99,0,           0,0,0,            1,1, 1,2,32'ha4,8));
    tv.push_back(mkv(1,1,0,32'h99,0,           0,0,0,            0,1, 0,0,32'h99,0));
    // simultaneous pipe and load with empty buffer
    tv.push_back(mkv(1,0,12,0,32'h1234,        1,13,32'hbeef,    0,1, 1,1,32'h1234,12));
    tv.push_back(mkv(0,0,0,0,0,                0,0,0,            0,1, 1,2,32'hbeef,13));
    // five back-to-back loads
    tv.push_back(mkv(0,0,0,0,0,                1,16,32'h100,     0,1, 0,2,32'hbeef,13));
    for (int k = 1; k < 5; k++)
      tv.push_back(mkv(0,0,0,0,0, 1,5'(16+k),32'h100+k, 0,1, 1,2,32'h100+k-1,5'(16+k-1)));
    tv.push_back(mkv(0,0,0,0,0,                0,0,0,            0,1, 1,2,32'h104,20));
    tv.push_back(mkv(0,0,0,0,0,                0,0,0,            0,1, 0,2,32'h104,20));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].pv, tv[i].jal, tv[i].prd, tv[i].pc, tv[i].alu, tv[i].lv, tv[i].lrd, tv[i].ldd);
      #1;
      chk($sformatf("vec%0d.pipe_stall", i), 64'(bus.pipe_stall), 64'(tv[i].es));
      chk($sformatf("vec%0d.ld_ready", i),   64'(bus.ld_ready),   64'(tv[i].er));
      @(posedge clk); #1;
      chk_regs($sformatf("vec%0d", i), tv[i].ew, tv[i].esel, tv[i].edata, tv[i].eaddr);
    end

    // mid-run reset with a load sitting in the buffer
    drive(0, 0, 0, 0, 0, 1, 21, 32'hdead);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_regs("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.ld_ready", 64'(bus.ld_ready), 64'd1);
    @(posedge clk); #1;
    chk_regs("rst_hold", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_regs("rst_after", 0, 0, 0, 0);
    chk("rst_after.ld_ready", 64'(bus.ld_ready), 64'd1);

    // randomized traffic against the reference model
    mq.delete();
    wait_cnt = 0;
    e_wren = 0; e_sel = 0; e_data = 0; e_addr = 0;
    begin
      logic prev_stall = 1'b0;
      logic prev_pend  = 1'b0;
      for (int i = 0; i < 500; i++) begin
        logic        pv, load_wins, pipe_wins, x_stall, x_ready;
        logic [36:0] ent;
        if (!prev_stall) begin
          bus.pipe_valid  = ($urandom_range(0, 9) < 6);
          bus.pipe_is_jal = 1'($urandom_range(0, 1));
          bus.pipe_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          bus.pc_four     = $urandom;
          bus.alu_data    = $urandom;
        end
        if (!prev_pend) begin
          bus.ld_valid = ($urandom_range(0, 9) < 7);
          bus.ld_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          bus.ld_data  = $urandom;
        end
        #1;
        pv        = bus.pipe_valid;
        load_wins = (mq.size() != 0) && !(pv && wait_cnt >= LIMIT);
        pipe_wins = pv && !load_wins;
        x_stall   = pv && !pipe_wins;
        x_ready   = (mq.size() == 0) || load_wins;
        chk($sformatf("rnd%0d.pipe_stall", i), 64'(bus.pipe_stall), 64'(x_stall));
        chk($sformatf("rnd%0d.ld_ready", i),   64'(bus.ld_ready),   64'(x_ready));
        if (load_wins) begin
          ent      = mq.pop_front();
          e_sel    = 2'd2;
          e_data   = ent[31:0];
          e_addr   = ent[36:32];
          e_wren   = (ent[36:32] != 5'd0);
          wait_cnt = pv ? wait_cnt + 1 : 0;
        end else if (pipe_wins) begin
          e_sel    = bus.pipe_is_jal ? 2'd0 : 2'd1;
          e_data   = bus.pipe_is_jal ? bus.pc_four : bus.alu_data;
          e_addr   = bus.pipe_rd;
          e_wren   = (bus.pipe_rd != 5'd0);
          wait_cnt = 0;
        end else begin
          e_wren   = 1'b0;
          wait_cnt = 0;
        end
        if (bus.ld_valid && x_ready) mq.push_back({bus.ld_rd, bus.ld_data});
        prev_stall = x_stall;
        prev_pend  = bus.ld_valid && !x_ready;
        @(posedge clk); #1;
        chk_regs($sformatf("rnd%0d", i), e_wren, e_sel, e_data, e_addr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
